uart_rx_os16: RTL and testbench

// - UART receiver with 16x oversampling, start-bit validation, stop-bit framing check and a one-entry output holding register with a valid/ready handshake.
// - Companion to the existing 8N1 Transmitter. Decodes the serial stream the Transmitter produces and hands bytes to a consumer that can stall.
// - Sits beside Transmitter inside the UART top. Rx comes straight from the pin.

---
 rtl/uart_rx_os16.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_rx_os16.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampled UART receiver (8N1 by default) with a one-entry valid/ready holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module uart_rx_os16 #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] Dout,
  output logic                 Dout_valid,
  input  logic                 Dout_ready,
  output logic                 Rx_done,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int DIV   = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_t;

  function automatic logic parity_even(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4,
    S_BREAK = 3'd5
  } state_t;
`endif

  state_t               state_r;
  logic                 rx_meta_r;
  logic                 rx_sync_r;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [3:0]           sample_cnt_r;
  logic [BIT_W-1:0]     bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic [DATA_BITS-1:0] dout_r;
  logic                 dout_valid_r;
  logic                 rx_done_r;
  logic                 frame_err_r;
  logic                 overrun_r;
`ifdef UART_RX_PARITY_EN
  logic                 par_err_r;
  logic                 parity_err_r;
`endif

  logic tick_s;
  logic mid_s;
  logic end_s;
  logic drain_s;

  // Two-flop synchronizer for the asynchronous serial input; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= Rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Oversample tick decode and handshake detection.
  always_comb begin
    tick_s  = (div_cnt_r == DIV_LAST);
    mid_s   = tick_s && (sample_cnt_r == 4'd7);
    end_s   = tick_s && (sample_cnt_r == 4'd15);
    drain_s = dout_valid_r && Dout_ready;
  end

  // Receive FSM with tick/sample/bit counters and the registered holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      div_cnt_r    <= {DIV_W{1'b0}};
      sample_cnt_r <= 4'd0;
      bit_cnt_r    <= {BIT_W{1'b0}};
      shift_r      <= {DATA_BITS{1'b0}};
      dout_r       <= {DATA_BITS{1'b0}};
      dout_valid_r <= 1'b0;
      rx_done_r    <= 1'b0;
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r    <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      rx_done_r   <= 1'b0;
      frame_err_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif

      // Restarting the divider on the start edge keeps every sample phase-aligned to it.
      if ((state_r == S_IDLE) && !rx_sync_r) begin
        div_cnt_r <= {DIV_W{1'b0}};
      end else if (tick_s) begin
        div_cnt_r <= {DIV_W{1'b0}};
      end else begin
        div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end

      if (tick_s) begin
        sample_cnt_r <= sample_cnt_r + 4'd1;
      end

      if (drain_s) begin
        dout_valid_r <= 1'b0;
        overrun_r    <= 1'b0;
      end

      case (state_r)
        S_IDLE: begin
          if (!rx_sync_r) begin
            state_r      <= S_START;
            sample_cnt_r <= 4'd0;
            bit_cnt_r    <= {BIT_W{1'b0}};
          end
        end
        S_START: begin
          if (mid_s) begin
            if (rx_sync_r) begin
              state_r <= S_IDLE;
            end else begin
              state_r      <= S_DATA;
              sample_cnt_r <= 4'd0;
            end
          end
        end
        S_DATA: begin
          if (end_s) begin
            shift_r <= DATA_BITS'({rx_sync_r, shift_r} >> 1);
            if (bit_cnt_r == BIT_LAST) begin
              bit_cnt_r <= {BIT_W{1'b0}};
`ifdef UART_RX_PARITY_EN
              state_r   <= S_PARITY;
`else
              state_r   <= S_STOP;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + {{(BIT_W-1){1'b0}}, 1'b1};
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (end_s) begin
            par_err_r <= (rx_sync_r != parity_even(shift_r));
            state_r   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (end_s) begin
            if (!rx_sync_r) begin
              frame_err_r <= 1'b1;
              state_r     <= S_BREAK;
`ifdef UART_RX_PARITY_EN
            end else if (par_err_r) begin
              parity_err_r <= 1'b1;
              state_r      <= S_IDLE;
`endif
            end else begin
              state_r <= S_IDLE;
              // A drain in this same cycle frees the slot, so the new byte still lands.
              if (!dout_valid_r || Dout_ready) begin
                dout_r       <= shift_r;
                dout_valid_r <= 1'b1;
                rx_done_r    <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end
          end
        end
        S_BREAK: begin
          if (rx_sync_r) begin
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign Dout       = dout_r;
  assign Dout_valid = dout_valid_r;
  assign Rx_done    = rx_done_r;
  assign frame_err  = frame_err_r;
  assign overrun    = overrun_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os16.sv
// Directed self-checking bench for uart_rx_os16 at DIV=10 (160 clocks per bit).
`timescale 1ns/1ps
module tb_uart_rx_os16;

  localparam int BIT_CLKS = 160;
`ifdef UART_RX_PARITY_EN
  localparam int LAT_EXP = 2 + (8 + 16 * 10) * 10;
`else
  localparam int LAT_EXP = 2 + (8 + 16 * 9) * 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Rx = 1'b1;
  logic       Dout_ready = 1'b1;
  logic [7:0] Dout;
  logic       Dout_valid;
  logic       Rx_done;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  logic [7:0] last_dout = 8'h00;
  int d0, f0, p0, lat;

  uart_rx_os16 #(
    .CLK_HZ(1_600_000),
    .BAUD(10_000),
    .OVERSAMPLE(16),
    .DATA_BITS(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .Rx(Rx),
    .Dout(Dout),
    .Dout_valid(Dout_valid),
    .Dout_ready(Dout_ready),
    .Rx_done(Rx_done),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (Rx_done) begin
      done_cnt  <= done_cnt + 1;
      done_cyc  <= cyc;
      last_dout <= Dout;
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    Rx = b;
    wait_clks(BIT_CLKS);
  endtask

  task automatic send_body(input logic [7:0] data);
    fall_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop);
    send_body(data);
`ifdef UART_RX_PARITY_EN
    send_bit(^data);
`endif
    send_bit(stop);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_bad_par(input logic [7:0] data);
    send_body(data);
    send_bit(~(^data));
    send_bit(1'b1);
  endtask
`endif

  initial begin
    wait_clks(3);
    check("rst_dout", Dout, 8'h00);
    check("rst_valid", Dout_valid, 1'b0);
    check("rst_done", Rx_done, 1'b0);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_perr", parity_err, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;
    wait_clks(20);

    // Good byte with the consumer always ready.
    d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_frame(8'hA5, 1'b1);
    wait_clks(20);
    lat = done_cyc - fall_cyc;
    check("a5_done", done_cnt - d0, 1);
    check("a5_dout", last_dout, 8'hA5);
    check("a5_ferr", ferr_cnt - f0, 0);
    check("a5_perr", perr_cnt - p0, 0);
    check("a5_overrun", overrun, 1'b0);
    check("a5_valid_drained", Dout_valid, 1'b0);
    check("a5_latency", (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) ? LAT_EXP : lat, LAT_EXP);

    // Low glitch that is over before the mid-start sample point (80 clk in).
    d0 = done_cnt; f0 = ferr_cnt;
    Rx = 1'b0;
    wait_clks(60);
    Rx = 1'b1;
    wait_clks(12 * BIT_CLKS);
    check("glitch_done", done_cnt - d0, 0);
    check("glitch_ferr", ferr_cnt - f0, 0);
    check("glitch_valid", Dout_valid, 1'b0);

    // Stop bit low, line then held low well beyond one frame before release.
    d0 = done_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0);
    wait_clks(12 * BIT_CLKS);
    Rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_done", done_cnt - d0, 0);
    check("break_valid", Dout_valid, 1'b0);

    // Stalled consumer: second byte is dropped and flagged.
    Dout_ready = 1'b0;
    d0 = done_cnt;
    send_frame(8'h11, 1'b1);
    wait_clks(2 * BIT_CLKS);
    check("ovr_first_dout", Dout, 8'h11);
    check("ovr_first_valid", Dout_valid, 1'b1);
    check("ovr_first_flag", overrun, 1'b0);
    send_frame(8'h22, 1'b1);
    wait_clks(BIT_CLKS);
    check("ovr_done_count", done_cnt - d0, 1);
    check("ovr_dout_kept", Dout, 8'h11);
    check("ovr_valid_kept", Dout_valid, 1'b1);
    check("ovr_flag", overrun, 1'b1);
    Dout_ready = 1'b1;
    wait_clks(1);
    check("ovr_drain_valid", Dout_valid, 1'b0);
    check("ovr_drain_flag", overrun, 1'b0);
    check("ovr_drain_dout", Dout, 8'h11);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x81.
    d0 = done_cnt; f0 = ferr_cnt; p0 = perr_cnt;
    send_bit(1'b0);
    repeat (4) send_bit(1'b1);
    wait_clks(80);
    rst = 1'b1;
    wait_clks(2);
    check("midrst_dout", Dout, 8'h00);
    check("midrst_valid", Dout_valid, 1'b0);
    rst = 1'b0;
    wait_clks(6 * BIT_CLKS);
    send_frame(8'h81, 1'b1);
    wait_clks(20);
    check("midrst_done", done_cnt - d0, 1);
    check("midrst_dout81", last_dout, 8'h81);
    check("midrst_ferr", ferr_cnt - f0, 0);
    check("midrst_perr", perr_cnt - p0, 0);
    check("midrst_overrun", overrun, 1'b0);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones, so its even-parity bit is 1.
    d0 = done_cnt; p0 = perr_cnt;
    send_frame_bad_par(8'h07);
    wait_clks(20);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_done", done_cnt - d0, 0);
    d0 = done_cnt; p0 = perr_cnt;
    send_frame(8'h07, 1'b1);
    wait_clks(20);
    check("par_good_done", done_cnt - d0, 1);
    check("par_good_dout", last_dout, 8'h07);
    check("par_good_perr", perr_cnt - p0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
